// File: rtl/hipercubo_pkg.sv
// hipercubo_pkg: sequencer state encoding and per-state enable/select masks
// for the 2x2 hypercube multiply datapath (node index n = binary kij).
package hipercubo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_UP,
        ST_BCAST,
        ST_WAIT,
        ST_CAPT,
        ST_DONE
    } state_t;

    localparam logic [7:0] EN_A_LOAD = 8'h0F;
    localparam logic [7:0] EN_B_LOAD = 8'h0F;
    localparam logic [7:0] EN_A_UP   = 8'hA0;
    localparam logic [7:0] EN_B_UP   = 8'hC0;
    localparam logic [7:0] EN_A_BC   = 8'h5A;
    localparam logic [7:0] EN_B_BC   = 8'h3C;
    localparam logic [7:0] EN_C_ALL  = 8'hFF;
    localparam logic [7:0] SEL_BC    = 8'hFF;

endpackage

// File: rtl/hipercubo_wait_cnt.sv
// hipercubo_wait_cnt: clear/increment counter flagging when it sits at LAST.
module hipercubo_wait_cnt #(
    parameter int               CNT_W = 4,
    parameter logic [CNT_W-1:0] LAST  = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tc = cnt_q == LAST;

endmodule

// File: rtl/hipercubo_control.sv
// hipercubo_control: Moore sequencer running one hypercube matrix multiply per
// accepted START: load, copy up, broadcast, optional settle wait, capture.
module hipercubo_control
    import hipercubo_pkg::*;
#(
    parameter int MUL_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic [7:0] ENa,
    output logic [7:0] ENb,
    output logic [7:0] ENc,
    output logic [7:0] SEL,
    output logic       BUSY,
    output logic       DONE,
    output logic       VALID
);

    // With no wait configured the counter is present but never leaves zero.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MUL_WAIT > 0 ? MUL_WAIT - 1 : 0);

    state_t state_q, state_d;
    logic   valid_q, valid_d;
    logic   wait_tc;

    hipercubo_wait_cnt #(
        .CNT_W(CNT_W),
        .LAST (WAIT_LAST)
    ) u_wait_cnt (
        .clk(CLK),
        .rst(RST),
        .clr(state_q == ST_WAIT && wait_tc),
        .inc(state_q == ST_WAIT),
        .tc (wait_tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ENa     = 8'h00;
        ENb     = 8'h00;
        ENc     = 8'h00;
        SEL     = 8'h00;
        BUSY    = 1'b0;
        DONE    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = START ? ST_LOAD : ST_IDLE;
                valid_d = START ? 1'b0 : valid_q;
            end
            ST_LOAD: begin
                ENa     = EN_A_LOAD;
                ENb     = EN_B_LOAD;
                BUSY    = 1'b1;
                state_d = ST_UP;
            end
            ST_UP: begin
                ENa     = EN_A_UP;
                ENb     = EN_B_UP;
                BUSY    = 1'b1;
                state_d = ST_BCAST;
            end
            ST_BCAST: begin
                ENa     = EN_A_BC;
                ENb     = EN_B_BC;
                SEL     = SEL_BC;
                BUSY    = 1'b1;
                state_d = (MUL_WAIT > 0) ? ST_WAIT : ST_CAPT;
            end
            ST_WAIT: begin
                BUSY    = 1'b1;
                state_d = wait_tc ? ST_CAPT : ST_WAIT;
            end
            ST_CAPT: begin
                // Products land at this edge, so the result is valid from DONE on.
                ENc     = EN_C_ALL;
                BUSY    = 1'b1;
                valid_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign VALID = valid_q;

endmodule
